// File: rtl/sum_series_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sum_series_pkg : shared types and defaults for the sum_series family  |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
package sum_series_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    RUN    = 2'd1,
    RESULT = 2'd2
  } sum_series_ctrl_state_t;

  localparam int          SUM_SERIES_N  = 100;
  localparam int          SUM_SERIES_DW = 32;
  localparam logic [31:0] FP32_ZERO     = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/sum_series_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sum_series_ctrl_if : sample stream, result stream and sum_series link |
// | Revision           : 1.0                                              |
// +----------------------------------------------------------------------+
interface sum_series_ctrl_if
  import sum_series_pkg::*;
#(
  parameter int N          = SUM_SERIES_N,
  parameter int DATA_WIDTH = SUM_SERIES_DW
);

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] data_array [0:N-1];
  logic                  start;
  logic                  done;
  logic [DATA_WIDTH-1:0] sum_output;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_valid;
  logic                  res_ready;
  logic                  res_err;

  // Controller side.
  modport slave (
    input  in_data, in_valid, done, sum_output, res_ready,
    output in_ready, data_array, start, res_data, res_valid, res_err
  );

  // System / accumulator side.
  modport master (
    output in_data, in_valid, done, sum_output, res_ready,
    input  in_ready, data_array, start, res_data, res_valid, res_err
  );

endinterface
`default_nettype wire

// File: rtl/sum_series_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sum_series_buf : N-entry sample register file with write pointer      |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
module sum_series_buf #(
  parameter int N          = 100,
  parameter int DATA_WIDTH = 32
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic                  we_i,
  input  wire logic                  clr_i,
  input  wire logic [DATA_WIDTH-1:0] wdata_i,
  output logic                       last_o,
  output logic [DATA_WIDTH-1:0]      data_o [0:N-1]
);

  localparam int               c_iw   = (N > 1) ? $clog2(N) : 1;
  localparam logic [c_iw-1:0]  c_last = c_iw'(N - 1);

  logic [c_iw-1:0] wr_idx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx_q <= '0;
    end else if (clr_i) begin
      wr_idx_q <= '0;
    end else if (we_i) begin
      wr_idx_q <= wr_idx_q + 1'b1;
    end
  end

  assign last_o = (wr_idx_q == c_last);

  // One register per entry so each slot has a single driver.
  for (genvar k = 0; k < N; k++) begin : g_entry
    logic [DATA_WIDTH-1:0] entry_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        entry_q <= '0;
      end else if (we_i && (wr_idx_q == c_iw'(k))) begin
        entry_q <= wdata_i;
      end
    end

    assign data_o[k] = entry_q;
  end

endmodule
`default_nettype wire

// File: rtl/sum_series_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sum_series_ctrl : fill / run / result front end for sum_series.       |
// | Optional watchdog: define SUM_SERIES_CTRL_TIMEOUT_EN.                 |
// | Revision        : 1.0                                                 |
// +----------------------------------------------------------------------+
module sum_series_ctrl
  import sum_series_pkg::*;
#(
  parameter int N              = SUM_SERIES_N,
  parameter int DATA_WIDTH     = SUM_SERIES_DW,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input wire logic          clk,
  input wire logic          reset,
  sum_series_ctrl_if.slave  bus
);

  sum_series_ctrl_state_t state_q;
  logic                   start_q;
  logic                   res_valid_q;
  logic [DATA_WIDTH-1:0]  res_data_q;
  logic                   w_last;
  logic                   w_accept;

  assign w_accept = (state_q == FILL) && bus.in_valid;

  sum_series_buf #(
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .we_i    (w_accept),
    .clr_i   (w_accept && w_last),
    .wdata_i (bus.in_data),
    .last_o  (w_last),
    .data_o  (bus.data_array)
  );

`ifdef SUM_SERIES_CTRL_TIMEOUT_EN
  localparam int              c_cw  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cw-1:0] c_lim = c_cw'(TIMEOUT_CYCLES - 1);
  logic [c_cw-1:0] tmo_cnt_q;
  logic            res_err_q;
  assign bus.res_err = res_err_q;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign bus.res_err      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
`ifdef SUM_SERIES_CTRL_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      res_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        FILL: begin
          if (w_accept && w_last) begin
            state_q <= RUN;
            start_q <= 1'b1;
`ifdef SUM_SERIES_CTRL_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
          end
        end
        RUN: begin
`ifdef SUM_SERIES_CTRL_TIMEOUT_EN
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
          // done takes priority over an expiring watchdog.
          if (bus.done) begin
            state_q     <= RESULT;
            start_q     <= 1'b0;
            res_valid_q <= 1'b1;
            res_data_q  <= bus.sum_output;
`ifdef SUM_SERIES_CTRL_TIMEOUT_EN
            res_err_q   <= 1'b0;
          end else if (tmo_cnt_q == c_lim) begin
            state_q     <= RESULT;
            start_q     <= 1'b0;
            res_valid_q <= 1'b1;
            res_data_q  <= '0;
            res_err_q   <= 1'b1;
`endif
          end
        end
        RESULT: begin
          if (bus.res_ready) begin
            state_q     <= FILL;
            res_valid_q <= 1'b0;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == FILL);
  assign bus.start     = start_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;

endmodule
`default_nettype wire

// File: tb/tb_sum_series_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sum_series_ctrl : directed bench for sum_series_ctrl with a        |
// | fixed-latency sum_series stub. Timeout case under                     |
// | SUM_SERIES_CTRL_TIMEOUT_EN.  Revision : 1.0                           |
// +----------------------------------------------------------------------+
module tb_sum_series_ctrl;

  localparam int c_n   = 100;
  localparam int c_dw  = 32;
  localparam int c_tmo = 64;

  logic clk;
  logic reset;

  int tests;
  int fails;

  // Stub state, advanced only inside tick().
  int          stub_lat;
  logic [31:0] stub_sum;
  logic        stub_en;
  logic        spur;
  int          scnt;

  sum_series_ctrl_if #(.N(c_n), .DATA_WIDTH(c_dw)) bus ();

  sum_series_ctrl #(
    .N              (c_n),
    .DATA_WIDTH     (c_dw),
    .TIMEOUT_CYCLES (c_tmo)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (stub_en && bus.start) begin
      scnt++;
      bus.done = (scnt >= stub_lat);
    end else begin
      scnt     = 0;
      bus.done = spur;
    end
    bus.sum_output = stub_sum;
  endtask

  // Streams N samples base + i*inc with in_valid held high.
  task automatic fill(input logic [31:0] base, input logic [31:0] inc);
    int early;
    early = 0;
    for (int i = 0; i < c_n; i++) begin
      if (bus.start !== 1'b0 || bus.in_ready !== 1'b1) early++;
      bus.in_valid = 1'b1;
      bus.in_data  = base + inc * i;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("fill_no_early_start", early, 0);
  endtask

  task automatic check_array(input string tag, input logic [31:0] base, input logic [31:0] inc);
    int          bad;
    logic [31:0] first_obs;
    logic [31:0] first_exp;
    bad = 0;
    first_obs = '0;
    first_exp = '0;
    for (int k = 0; k < c_n; k++) begin
      if (bus.data_array[k] !== base + inc * k) begin
        if (bad == 0) begin
          first_obs = bus.data_array[k];
          first_exp = base + inc * k;
        end
        bad++;
      end
    end
    chk(tag, first_obs, first_exp);
    chk({tag, "_count"}, bad, 0);
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int accepts;
    int early;
    int bp_bad_v, bp_bad_d, bp_bad_r;

    tests = 0;
    fails = 0;
    stub_lat = 20;
    stub_sum = 32'h4404_8000;
    stub_en  = 1'b1;
    spur     = 1'b0;
    scnt     = 0;
    bus.in_data    = '0;
    bus.in_valid   = 1'b0;
    bus.done       = 1'b0;
    bus.sum_output = '0;
    bus.res_ready  = 1'b0;

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_in_ready",  bus.in_ready,  1);
    chk("rst_start",     bus.start,     0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_err",   bus.res_err,   0);
    chk("rst_res_data",  bus.res_data,  0);
    check_array("rst_array", 32'h0, 32'h0);

    // Fill and pass-through.
    fill(32'h40A9_999A, 32'h0);
    chk("t1_start_rise", bus.start,    1);
    chk("t1_in_ready",   bus.in_ready, 0);
    check_array("t1_array", 32'h40A9_999A, 32'h0);
    wait_result(n);
    chk("t1_latency",  n,             20);
    chk("t1_res_data", bus.res_data,  32'h4404_8000);
    chk("t1_res_err",  bus.res_err,   0);
    chk("t1_start_lo", bus.start,     0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("t1_in_ready_after", bus.in_ready,  1);
    chk("t1_valid_dropped",  bus.res_valid, 0);

    // Gapped input with index pattern.
    stub_lat = 5;
    stub_sum = 32'h3F80_0000;
    accepts = 0;
    early   = 0;
    for (int i = 0; i < 2 * c_n; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_data  = 32'(i / 2);
      if (bus.start === 1'b1 && accepts < c_n) early++;
      if (bus.in_valid && bus.in_ready) accepts++;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("t2_accepts",  accepts, c_n);
    chk("t2_no_early", early,   0);
    check_array("t2_array", 32'h0, 32'h1);
    wait_result(n);
    chk("t2_res_valid", bus.res_valid, 1);
    chk("t2_res_data",  bus.res_data,  32'h3F80_0000);

    // Result backpressure; offered samples must not disturb the buffer.
    bp_bad_v = 0;
    bp_bad_d = 0;
    bp_bad_r = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.res_valid !== 1'b1)           bp_bad_v++;
      if (bus.res_data !== 32'h3F80_0000)   bp_bad_d++;
      if (bus.in_ready !== 1'b0)            bp_bad_r++;
    end
    bus.in_valid = 1'b0;
    chk("t3_valid_stable", bp_bad_v, 0);
    chk("t3_data_stable",  bp_bad_d, 0);
    chk("t3_in_ready_lo",  bp_bad_r, 0);
    check_array("t3_frozen", 32'h0, 32'h1);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("t3_in_ready_hi", bus.in_ready, 1);

    // Mid-fill reset after 37 accepts.
    for (int i = 0; i < 37; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hA000_0000 + 32'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_in_ready",  bus.in_ready,  1);
    chk("t4_start",     bus.start,     0);
    chk("t4_res_valid", bus.res_valid, 0);
    chk("t4_res_data",  bus.res_data,  0);
    check_array("t4_cleared", 32'h0, 32'h0);
    fill(32'hB000_0000, 32'h1);
    chk("t4_start_rise", bus.start, 1);
    check_array("t4_array", 32'hB000_0000, 32'h1);

    // Reset while running drops start on the same edge.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_run_rst_start", bus.start,    0);
    chk("t4_run_rst_ready", bus.in_ready, 1);

    // Spurious done during FILL.
    spur = 1'b1;
    tick();
    tick();
    tick();
    spur = 1'b0;
    chk("t5_no_valid", bus.res_valid, 0);
    chk("t5_in_ready", bus.in_ready,  1);
    chk("t5_start",    bus.start,     0);
    tick();
    stub_lat = 3;
    stub_sum = 32'hC2C8_0000;
    fill(32'h0000_1000, 32'h3);
    wait_result(n);
    chk("t5_latency",  n,            3);
    chk("t5_res_data", bus.res_data, 32'hC2C8_0000);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;

`ifdef SUM_SERIES_CTRL_TIMEOUT_EN
    // Watchdog: stub never answers.
    stub_en = 1'b0;
    fill(32'h1234_0000, 32'h1);
    chk("t6_start_rise", bus.start, 1);
    wait_result(n);
    chk("t6_latency",  n,             c_tmo);
    chk("t6_res_err",  bus.res_err,   1);
    chk("t6_res_data", bus.res_data,  0);
    chk("t6_start_lo", bus.start,     0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("t6_in_ready", bus.in_ready, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sum_series_ctrl.md
# sum_series_ctrl

Front-end controller that drives the `sum_series` accumulator from the system side. It accepts a stream of IEEE-754 single-precision samples over a valid/ready handshake and buffers N of them into the parallel `data_array` that `sum_series` consumes. It then runs the `start`/`done` exchange and returns the captured `sum_output` over a second valid/ready handshake. One instance sits directly in front of each `sum_series` instance.

## Interface
- `N`, 100: samples per series; buffer depth.
- `DATA_WIDTH`, 32: sample and sum width (fp32 bit patterns, treated as opaque).
- `TIMEOUT_CYCLES`, 4096: watchdog limit. Used only with `SUM_SERIES_CTRL_TIMEOUT_EN`.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  DATA_WIDTH  sample to buffer.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  controller can accept a sample.
- `data_array`  out  DATA_WIDTH × [0:N-1]  buffered samples, wired to `sum_series.data_array`.
- `start`  out  1  run request to `sum_series`.
- `done`  in  1  completion from `sum_series`.
- `sum_output`  in  DATA_WIDTH  result from `sum_series`.
- `res_data`  out  DATA_WIDTH  captured sum.
- `res_valid`  out  1  `res_data`/`res_err` are valid.
- `res_ready`  in  1  downstream accepts the result.
- `res_err`  out  1  run aborted by the watchdog. Constant 0 when the macro is absent.

## Operation
- FSM states: `FILL`, `RUN`, `RESULT`.
- Reset state is `FILL`, with `wr_idx`=0, `start`=0, `res_valid`=0, `res_err`=0, `res_data`=0, and every `data_array` entry at 0.
- **FILL**
  - `in_ready`=1.
  - On `in_valid && in_ready`: `data_array[wr_idx]` ← `in_data`, then `wr_idx`++.
  - The accept at `wr_idx`==N-1 moves the FSM to `RUN` and sets `wr_idx` to 0. There is no wrap within a series.
- **RUN**
  - `in_ready`=0.
  - `start` is registered and held at 1 for every cycle in `RUN`.
  - `done` is sampled only in `RUN`. When `done`=1: `res_data` ← `sum_output`, `res_err`←0, `start`←0, go to `RESULT`.
  - `data_array` is frozen throughout `RUN` and `RESULT`.
- **RESULT**
  - `res_valid`=1; `res_data` and `res_err` are held stable until the handshake.
  - On `res_valid && res_ready`: `res_valid`←0, go to `FILL`.
- `done` asserted outside `RUN` is ignored.
- `in_valid` outside `FILL` is not accepted. Upstream holds the sample until `in_ready`.
- `reset` mid-operation, in any state, returns to the reset state on the next edge. A partial fill is discarded and `start` drops in the same cycle.
- No arithmetic is performed on the data. Samples and the sum are passed through bit-exact.

## Timing
- Sample accept: one per cycle while in `FILL`. `in_ready` is a decode of the state, with no combinational path from `in_valid`.
- The last accept at cycle t gives `start`=1 at cycle t+1.
- `done`=1 sampled at cycle d gives `res_valid`=1 and `start`=0 at cycle d+1.
- The handshake at cycle h gives `in_ready`=1 at h+1.
- Minimum series turnaround is N + 1 + (`sum_series` latency) + 1 + 1 cycles.
- All outputs are registered or state-decoded.

## Configuration
- `SUM_SERIES_CTRL_TIMEOUT_EN` defined:
  - A counter, cleared on entry to `RUN`, increments every cycle in `RUN`.
  - If it reaches `TIMEOUT_CYCLES` with no `done`: go to `RESULT` with `res_err`=1, `res_data`=0, `start`=0.
  - If `done` arrives in the same cycle as the limit, `done` wins and `res_err`=0.
- `SUM_SERIES_CTRL_TIMEOUT_EN` undefined:
  - No counter logic is built; `res_err` is tied to 0.
  - `RUN` waits indefinitely for `done`.

## Structure
- Shared package `sum_series_pkg`:
  - state enum `sum_series_ctrl_state_t` (`FILL`, `RUN`, `RESULT`);
  - defaults `SUM_SERIES_N`=100, `SUM_SERIES_DW`=32;
  - constant `FP32_ZERO`=32'h0000_0000.
- Sub-module `sum_series_buf`: N×DATA_WIDTH register file with write pointer, write enable, pointer clear, and `last` flag. The FSM stays in the top level.

## Test plan
Each scenario uses a behavioural `sum_series` stub that raises `done` a fixed number of cycles after `start` and drives a chosen `sum_output`.
- **Fill and pass-through.** Stream 100 × 32'h40A9999A (5.3) with `in_valid` held high; stub drives 32'h44048000 (530.0) with 20-cycle latency.
  - Every `data_array` entry = 32'h40A9999A.
  - `start` rises one cycle after the 100th accept.
  - `res_data`=32'h44048000 and `res_err`=0.
- **Gapped input.** Toggle `in_valid` every other cycle.
  - Exactly 100 accepts.
  - `start` does not assert early.
  - `data_array[k]` = k-th sample, checked with an index-valued pattern 0..99.
- **Result backpressure.** Hold `res_ready`=0 for 50 cycles.
  - `res_valid` and `res_data` stay stable.
  - `in_ready` stays 0.
  - After `res_ready`=1, `in_ready`=1 on the next cycle.
- **Mid-fill reset.** Assert `reset` after 37 accepts.
  - All outputs return to reset values.
  - The next 100 samples form a complete series starting at index 0.
- **Spurious done.** Pulse `done` during `FILL`: no state change and no `res_valid`.
- **Timeout** (macro defined, `TIMEOUT_CYCLES`=64). Stub never raises `done`.
  - `res_valid`=1 with `res_err`=1 and `res_data`=0 exactly 64 cycles after `start` rose.
  - `start`=0 from that cycle.
